// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO bus responder: register map, STATUS/CONTROL
// bit positions and the data path width.
package io_bus_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_RSVD    = 2'd3
  } reg_off_e;

  localparam int unsigned ST_TX_FULL    = 0;
  localparam int unsigned ST_TX_EMPTY   = 1;
  localparam int unsigned ST_RX_FULL    = 2;
  localparam int unsigned ST_RX_EMPTY   = 3;
  localparam int unsigned ST_OVERFLOW   = 4;
  localparam int unsigned ST_UNDERFLOW  = 5;
  localparam int unsigned ST_RX_COUNT   = 8;
  localparam int unsigned ST_RX_COUNT_W = 5;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_FLUSH  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with occupancy count; full/empty judged on cycle-start state,
// flush overrides push and pop.
module io_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic           do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: contents are only observable once count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/io_bus_responder.sv
// CPU IO-port register block bridging DATA/STATUS/CONTROL accesses to a
// device-side TX/RX stream pair through two FIFOs.
module io_bus_responder
  import io_bus_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'h10,
  parameter int unsigned DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        io_addr,
  input  logic [DATA_W-1:0] io_data,
  input  logic              io_wr,
  input  logic              io_rd,
  output logic [DATA_W-1:0] io_rd_data,
  output logic              io_rd_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  reg_off_e          off;
  logic              hit, rd_hit, wr_hit;
  logic              enable_q, enable_d, irq_en_q, irq_en_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop, flush;
  logic              ovf_set, udf_set, status_rd;
  logic [CW-1:0]     tx_count, rx_count;
  logic [DATA_W-1:0] rx_head, status;

  assign hit    = (io_addr[7:2] == BASE_ADDR[7:2]);
  assign rd_hit = hit && io_rd;
  assign wr_hit = hit && io_wr;
  assign off    = reg_off_e'(io_addr[1:0]);

  assign tx_valid = enable_q && !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_ready = enable_q && !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign irq      = irq_en_q && (!rx_empty || ovf_q);

  always_comb begin
    flush     = wr_hit && (off == REG_CONTROL) && io_data[CTRL_FLUSH];
    tx_push   = wr_hit && (off == REG_DATA) && enable_q && !tx_full;
    ovf_set   = wr_hit && (off == REG_DATA) && tx_full;
    rx_pop    = rd_hit && (off == REG_DATA) && !rx_empty;
    udf_set   = rd_hit && (off == REG_DATA) && rx_empty;
    status_rd = rd_hit && (off == REG_STATUS);
  end

  always_comb begin
    status                                    = '0;
    status[ST_TX_FULL]                        = tx_full;
    status[ST_TX_EMPTY]                       = tx_empty;
    status[ST_RX_FULL]                        = rx_full;
    status[ST_RX_EMPTY]                       = rx_empty;
    status[ST_OVERFLOW]                       = ovf_q;
    status[ST_UNDERFLOW]                      = udf_q;
    status[ST_RX_COUNT +: ST_RX_COUNT_W]      = ST_RX_COUNT_W'(rx_count);
  end

  always_comb begin
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    rd_valid_d = rd_hit;
    rd_data_d  = rd_data_q;
    // Clear-on-read is applied first so a same-cycle set event wins.
    ovf_d      = (ovf_q && !status_rd) || ovf_set;
    udf_d      = (udf_q && !status_rd) || udf_set;

    if (wr_hit && (off == REG_CONTROL)) begin
      enable_d = io_data[CTRL_ENABLE];
      irq_en_d = io_data[CTRL_IRQ_EN];
    end

    if (rd_hit) begin
      case (off)
        REG_DATA:    rd_data_d = rx_empty ? '0 : rx_head;
        REG_STATUS:  rd_data_d = status;
        REG_CONTROL: begin
          rd_data_d              = '0;
          rd_data_d[CTRL_ENABLE] = enable_q;
          rd_data_d[CTRL_IRQ_EN] = irq_en_q;
        end
        default:     rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign io_rd_data  = rd_data_q;
  assign io_rd_valid = rd_valid_q;

  io_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (flush),
    .wdata (io_data),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  io_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (flush),
    .wdata (rx_data),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  count_bound_a: assert property (@(posedge clk) disable iff (!rst)
    (tx_count <= CW'(DEPTH)) && (rx_count <= CW'(DEPTH)));

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed bench for io_bus_responder with hand-computed expected values.
module tb_io_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  io_addr;
  logic [15:0] io_data;
  logic        io_wr, io_rd;
  logic [15:0] io_rd_data;
  logic        io_rd_valid;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [7:0] A_DATA = 8'h10;
  localparam logic [7:0] A_STAT = 8'h11;
  localparam logic [7:0] A_CTRL = 8'h12;
  localparam logic [7:0] A_RSVD = 8'h13;

  always #5 clk = ~clk;

  io_bus_responder #(.BASE_ADDR(8'h10), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_addr     (io_addr),
    .io_data     (io_data),
    .io_wr       (io_wr),
    .io_rd       (io_rd),
    .io_rd_data  (io_rd_data),
    .io_rd_valid (io_rd_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .irq         (irq)
  );

  task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
    io_addr = a; io_data = d; io_wr = 1'b1;
    @(posedge clk); #1;
    io_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [15:0] d, output logic v);
    io_addr = a; io_rd = 1'b1;
    @(posedge clk); #1;
    io_rd = 1'b0;
    d = io_rd_data; v = io_rd_valid;
  endtask

  task automatic test_reset();
    logic [15:0] d; logic v;
    rst = 1'b0; io_addr = '0; io_data = '0; io_wr = 0; io_rd = 0;
    tx_ready = 0; rx_data = '0; rx_valid = 0;
    #4;
    vectors++; if ({io_rd_valid, tx_valid, rx_ready, irq} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b expected %b", {io_rd_valid, tx_valid, rx_ready, irq}, 4'b0000); end
    vectors++; if (io_rd_data !== 16'h0000) begin miscompares++; $display("FAIL reset_rd_data: got %h expected %h", io_rd_data, 16'h0000); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cpu_read(A_STAT, d, v);
    vectors++; if ({v, d} !== {1'b1, 16'h000A}) begin miscompares++; $display("FAIL reset_status: got %b/%h expected 1/000a", v, d); end
    cpu_read(A_CTRL, d, v);
    vectors++; if ({v, d} !== {1'b1, 16'h0000}) begin miscompares++; $display("FAIL reset_control: got %b/%h expected 1/0000", v, d); end
  endtask

  task automatic test_tx_stream();
    tx_ready = 1'b1;
    cpu_write(A_CTRL, 16'h0001);
    io_addr = A_DATA; io_data = 16'h1234; io_wr = 1'b1;
    #1;
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL tx_valid_write_cycle: got %b expected 0", tx_valid); end
    @(posedge clk); #1;
    vectors++; if ({tx_valid, tx_data} !== {1'b1, 16'h1234}) begin miscompares++; $display("FAIL tx_first: got %b/%h expected 1/1234", tx_valid, tx_data); end
    io_data = 16'h5678;
    @(posedge clk); #1;
    io_wr = 1'b0;
    vectors++; if ({tx_valid, tx_data} !== {1'b1, 16'h5678}) begin miscompares++; $display("FAIL tx_second: got %b/%h expected 1/5678", tx_valid, tx_data); end
    @(posedge clk); #1;
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL tx_drained: got %b expected 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [15:0] d; logic v;
    for (int i = 1; i <= 5; i++) cpu_write(A_DATA, 16'(i));
    vectors++; if ({tx_valid, tx_data} !== {1'b1, 16'h0001}) begin miscompares++; $display("FAIL ovf_head: got %b/%h expected 1/0001", tx_valid, tx_data); end
    cpu_read(A_STAT, d, v);
    vectors++; if (d !== 16'h0019) begin miscompares++; $display("FAIL ovf_status1: got %h expected 0019", d); end
    cpu_read(A_STAT, d, v);
    vectors++; if (d !== 16'h0009) begin miscompares++; $display("FAIL ovf_status2: got %h expected 0009", d); end
    // push into a full FIFO while it pops: rejected, overflow set
    tx_ready = 1'b1;
    cpu_write(A_DATA, 16'h0006);
    for (int i = 2; i <= 4; i++) begin
      vectors++; if ({tx_valid, tx_data} !== {1'b1, 16'(i)}) begin miscompares++; $display("FAIL ovf_drain: got %b/%h expected 1/%h", tx_valid, tx_data, 16'(i)); end
      @(posedge clk); #1;
    end
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_rejected_push: got tx_valid %b expected 0", tx_valid); end
    tx_ready = 1'b0;
    cpu_read(A_STAT, d, v);
    vectors++; if (d !== 16'h001A) begin miscompares++; $display("FAIL ovf_status3: got %h expected 001a", d); end
  endtask

  task automatic test_rx_irq();
    logic [15:0] d; logic v;
    cpu_write(A_CTRL, 16'h0005);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_idle: got %b expected 0", irq); end
    rx_data = 16'hAAAA; rx_valid = 1'b1;
    #1;
    vectors++; if (rx_ready !== 1'b1) begin miscompares++; $display("FAIL rx_ready: got %b expected 1", rx_ready); end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_rx: got %b expected 1", irq); end
    cpu_read(A_STAT, d, v);
    vectors++; if (d !== 16'h0102) begin miscompares++; $display("FAIL rx_status: got %h expected 0102", d); end
    cpu_read(A_DATA, d, v);
    vectors++; if ({v, d} !== {1'b1, 16'hAAAA}) begin miscompares++; $display("FAIL rx_data: got %b/%h expected 1/aaaa", v, d); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear: got %b expected 0", irq); end
    cpu_read(A_DATA, d, v);
    vectors++; if ({v, d} !== {1'b1, 16'h0000}) begin miscompares++; $display("FAIL rx_empty_read: got %b/%h expected 1/0000", v, d); end
    cpu_read(A_STAT, d, v);
    vectors++; if (d !== 16'h002A) begin miscompares++; $display("FAIL udf_status: got %h expected 002a", d); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d; logic v;
    for (int i = 0; i < 4; i++) begin
      rx_data = 16'h1000 + 16'(i); rx_valid = 1'b1;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    vectors++; if (rx_ready !== 1'b0) begin miscompares++; $display("FAIL rx_full_ready: got %b expected 0", rx_ready); end
    cpu_read(A_STAT, d, v);
    vectors++; if (d !== 16'h0406) begin miscompares++; $display("FAIL rx_full_status: got %h expected 0406", d); end
    // simultaneous DATA write and DATA read
    io_addr = A_DATA; io_data = 16'h5555; io_wr = 1'b1; io_rd = 1'b1;
    @(posedge clk); #1;
    io_wr = 1'b0; io_rd = 1'b0;
    vectors++; if ({io_rd_valid, io_rd_data} !== {1'b1, 16'h1000}) begin miscompares++; $display("FAIL concurrent_rd: got %b/%h expected 1/1000", io_rd_valid, io_rd_data); end
    vectors++; if ({tx_valid, tx_data, rx_ready} !== {1'b1, 16'h5555, 1'b1}) begin miscompares++; $display("FAIL concurrent_wr: got %b/%h/%b expected 1/5555/1", tx_valid, tx_data, rx_ready); end
  endtask

  task automatic test_flush();
    logic [15:0] d; logic v;
    cpu_write(A_DATA, 16'h6666);
    cpu_write(A_DATA, 16'h7777);
    tx_ready = 1'b1;
    io_addr = A_CTRL; io_data = 16'h0003; io_wr = 1'b1;
    #1;
    vectors++; if ({tx_valid, tx_data} !== {1'b1, 16'h5555}) begin miscompares++; $display("FAIL flush_handshake: got %b/%h expected 1/5555", tx_valid, tx_data); end
    @(posedge clk); #1;
    io_wr = 1'b0;
    vectors++; if ({tx_valid, rx_ready, irq} !== 3'b010) begin miscompares++; $display("FAIL flush_flags: got %b expected 010", {tx_valid, rx_ready, irq}); end
    tx_ready = 1'b0;
    cpu_read(A_STAT, d, v);
    vectors++; if (d !== 16'h000A) begin miscompares++; $display("FAIL flush_status: got %h expected 000a", d); end
    cpu_read(A_CTRL, d, v);
    vectors++; if (d !== 16'h0001) begin miscompares++; $display("FAIL flush_ctrl: got %h expected 0001", d); end
  endtask

  task automatic test_decode();
    logic [15:0] d; logic v;
    cpu_read(8'h00, d, v);
    vectors++; if ({v, d} !== {1'b0, 16'h0001}) begin miscompares++; $display("FAIL nonhit_read: got %b/%h expected 0/0001", v, d); end
    cpu_write(A_RSVD, 16'hFFFF);
    cpu_read(A_RSVD, d, v);
    vectors++; if ({v, d} !== {1'b1, 16'h0000}) begin miscompares++; $display("FAIL rsvd_read: got %b/%h expected 1/0000", v, d); end
    cpu_read(A_CTRL, d, v);
    vectors++; if (d !== 16'h0001) begin miscompares++; $display("FAIL rsvd_write_ignored: got %h expected 0001", d); end
    cpu_write(8'h20, 16'h9999);
    vectors++; if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL nonhit_write: got tx_valid %b expected 0", tx_valid); end
  endtask

  task automatic test_async_reset();
    logic [15:0] d; logic v;
    cpu_write(A_CTRL, 16'h0005);
    cpu_write(A_DATA, 16'h0AAA);
    cpu_write(A_DATA, 16'h0BBB);
    rx_data = 16'h0CCC; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    vectors++; if ({tx_valid, irq} !== 2'b11) begin miscompares++; $display("FAIL pre_reset: got %b expected 11", {tx_valid, irq}); end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (tx_data !== 16'h0BBB) begin miscompares++; $display("FAIL mid_drain: got %h expected 0bbb", tx_data); end
    #2 rst = 1'b0;
    #1;
    vectors++; if ({tx_valid, irq, rx_ready, io_rd_valid} !== 4'b0000) begin miscompares++; $display("FAIL async_reset_flags: got %b expected 0000", {tx_valid, irq, rx_ready, io_rd_valid}); end
    vectors++; if (io_rd_data !== 16'h0000) begin miscompares++; $display("FAIL async_reset_rd_data: got %h expected 0000", io_rd_data); end
    tx_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    cpu_read(A_STAT, d, v);
    vectors++; if ({v, d} !== {1'b1, 16'h000A}) begin miscompares++; $display("FAIL post_reset_status: got %b/%h expected 1/000a", v, d); end
    cpu_read(A_CTRL, d, v);
    vectors++; if (d !== 16'h0000) begin miscompares++; $display("FAIL post_reset_ctrl: got %h expected 0000", d); end
  endtask

  initial begin
    test_reset();
    test_tx_stream();
    test_overflow();
    test_rx_irq();
    test_back_to_back();
    test_flush();
    test_decode();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_bus_responder.md
IO_BUS_RESPONDER -- requirements
Module: io_bus_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 8'h10: IO address of register 0; bits [1:0] are ignored.
REQ-002 The block SHALL have parameter DEPTH, default 4: entries per FIFO; power of two, 2..16.
REQ-003 The block SHALL have port clk  in  1  the single clock; all state changes on posedge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port io_addr  in  8  IO address from the CPU IO address register.
REQ-006 The block SHALL have port io_data  in  16  IO write data from the CPU IO data register.
REQ-007 The block SHALL have port io_wr  in  1  write strobe, one cycle per access.
REQ-008 The block SHALL have port io_rd  in  1  read strobe, one cycle per access.
REQ-009 The block SHALL have port io_rd_data  out  16  registered read data.
REQ-010 The block SHALL have port io_rd_valid  out  1  one-cycle pulse qualifying io_rd_data.
REQ-011 The block SHALL have ports tx_data out 16, tx_valid out 1 and tx_ready in 1: device-side output stream.
REQ-012 The block SHALL have ports rx_data in 16, rx_valid in 1 and rx_ready out 1: device-side input stream.
REQ-013 The block SHALL have port irq  out  1  level interrupt request.

Function
REQ-014 The block SHALL register a hit when io_addr[7:2]==BASE_ADDR[7:2] with io_rd or io_wr high.
REQ-015 The block SHALL decode io_addr[1:0] as 0 DATA, 1 STATUS, 2 CONTROL, 3 reserved (read 0, writes ignored).
REQ-016 The block SHALL make io_rd_data and io_rd_valid valid exactly one cycle after the io_rd hit cycle; io_rd_data holds until the next read.
REQ-017 The block SHALL give a non-hit io_rd no response (io_rd_valid stays 0).
REQ-018 A DATA write SHALL push io_data into the TX FIFO when enable=1 and TX is not full at that edge; otherwise the write is dropped and sticky overflow is set (overflow only when TX is full).
REQ-019 Fullness SHALL be judged on the cycle-start state: a push to a full TX FIFO is rejected even if a tx pop occurs in the same cycle.
REQ-020 A DATA read SHALL return the RX head and pop it; if RX is empty it returns 16'h0000 and sets sticky underflow.
REQ-021 A STATUS read SHALL return bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 overflow, bit5 underflow, bits[12:8] rx_count, others 0.
REQ-022 A STATUS read SHALL clear overflow and underflow at the same edge the returned value is captured; a set event in that same cycle wins.
REQ-023 CONTROL SHALL hold bit0 enable, bit1 flush (self-clearing, reads 0) and bit2 irq_en; a read returns {13'b0, irq_en, 1'b0, enable}.
REQ-024 Flush SHALL empty both FIFOs at the edge after the CONTROL write and take priority over any push or pop in that cycle.
REQ-025 tx_valid SHALL equal enable AND TX-not-empty; tx_data SHALL be the TX head; a pop occurs on tx_valid&tx_ready.
REQ-026 A write into an empty TX FIFO SHALL raise tx_valid on the next cycle (one-cycle latency).
REQ-027 rx_ready SHALL equal enable AND RX-not-full; an entry is captured on rx_valid&rx_ready.
REQ-028 Simultaneous io_wr and io_rd, and a CPU access concurrent with a device handshake, SHALL each be processed independently in the same cycle.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; counts SHALL be $clog2(DEPTH)+1 bits wide and never exceed DEPTH.
REQ-030 irq SHALL equal irq_en AND (RX-not-empty OR overflow), driven from registers with no combinational path from inputs.

Reset
REQ-031 rst low SHALL asynchronously clear both FIFOs, enable, irq_en, overflow, underflow, io_rd_data, io_rd_valid, tx_valid, rx_ready and irq.
REQ-032 On reset release the block SHALL return to normal operation on the first clk edge with rst high; an access interrupted by reset is lost.

Structure
REQ-033 Shared package io_bus_pkg SHALL hold the register offsets, the STATUS and CONTROL bit indices and the 16-bit data width constant.
REQ-034 The FIFO SHALL be a sub-module io_fifo (parameterised DEPTH and WIDTH, push, pop, flush, full, empty, count), instantiated once each for TX and RX.

Verification
REQ-035 Reset, then write CONTROL=0x0001, then DATA 0x1234 and 0x5678 with tx_ready=1 -> tx_data shows 0x1234 then 0x5678 on consecutive handshakes, and tx_valid rises one cycle after the first write.
REQ-036 enable=1, tx_ready=0, five DATA writes with DEPTH=4 -> STATUS read returns tx_full=1 and overflow=1; a second STATUS read shows overflow=0.
REQ-037 Drive rx_data 0xAAAA with rx_valid=1, irq_en=1 -> irq goes to 1; a DATA read gives io_rd_valid one cycle later with 0xAAAA; irq goes to 0; another DATA read returns 0x0000 and sets underflow.
REQ-038 Fill TX with 3 entries, then write CONTROL=0x0003 in the same cycle as a tx handshake -> both FIFOs empty next cycle, and STATUS reads tx_empty=1, rx_empty=1.
REQ-039 Read io_addr=BASE_ADDR+3 and io_addr=8'h00 (non-hit) -> the first returns 0x0000 with io_rd_valid; the second gives no io_rd_valid pulse.
REQ-040 Assert rst low in the middle of a TX drain -> tx_valid, irq and the counts drop to 0 immediately, without waiting for clk.
